// File: rtl/ifq_pkg.sv
// Shared constants for the instruction-fetch queue (NOP filler, reset PC, PC step).
// Latency: n/a (constants only).
// Backpressure: n/a.
package ifq_pkg;

    // Instruction presented downstream whenever no real instruction is available.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // First fetch address after reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential fetch stride in bytes.
    localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/ifq_ring.sv
// DEPTH-entry fetch ring: pc written at request issue, instruction written at response.
// Latency: writes visible at the head read port one cycle after the write edge.
// Backpressure: none internally; the caller guarantees entries are only allocated when free.
//
// Ports: alloc_* writes the pc and clears the filled bit of a newly issued entry;
// fill_* writes the returned instruction and sets filled; deq_en clears filled at
// the head; clear drops every filled bit; head_* reads the oldest entry.
module ifq_ring
    import ifq_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_SIZE  = 32,
    parameter int INSTR_SIZE = 32,
    localparam int PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  alloc_en,
    input  logic [PW-1:0]         alloc_idx,
    input  logic [ADDR_SIZE-1:0]  alloc_pc,
    input  logic                  fill_en,
    input  logic [PW-1:0]         fill_idx,
    input  logic [INSTR_SIZE-1:0] fill_instr,
    input  logic                  deq_en,
    input  logic [PW-1:0]         head_idx,
    output logic [ADDR_SIZE-1:0]  head_pc,
    output logic [INSTR_SIZE-1:0] head_instr,
    output logic                  head_filled
);

    logic [ADDR_SIZE-1:0]  pc_mem    [DEPTH];
    logic [INSTR_SIZE-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]      filled;

    // Payload storage needs no reset: an entry is only read once it is allocated/filled.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            pc_mem[alloc_idx] <= alloc_pc;
        end
        if (fill_en) begin
            instr_mem[fill_idx] <= fill_instr;
        end
    end

    // Dequeue clears filled so a stale bit cannot reappear when the head wraps onto
    // an entry that has not been reallocated yet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filled <= '0;
        end else if (clear) begin
            filled <= '0;
        end else begin
            if (alloc_en) begin
                filled[alloc_idx] <= 1'b0;
            end
            if (fill_en) begin
                filled[fill_idx] <= 1'b1;
            end
            if (deq_en) begin
                filled[head_idx] <= 1'b0;
            end
        end
    end

    assign head_pc     = pc_mem[head_idx];
    assign head_instr  = instr_mem[head_idx];
    assign head_filled = filled[head_idx];

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, issues in-order imem requests, queues returned words.
// Latency: response at edge N gives instr_valid from cycle N+1 (same cycle with IFQ_BYPASS_EN).
// Backpressure: issue stops when queued + to-be-dropped requests reach DEPTH; stallF holds the head.
//
// Ports: clk/reset (async, active-low); imem_req_* request channel; imem_rsp_* in-order
// response channel; redirect/redirect_pc from EX; stallF from the hazard unit;
// instr_valid/instrF/pcF towards the IF/ID register.
// Optional macro IFQ_BYPASS_EN: forward a response aimed at an empty head straight to instrF.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH                     = 4,
    parameter int ADDR_SIZE                 = 32,
    parameter int INSTR_SIZE                = 32,
    parameter logic [ADDR_SIZE-1:0] RESET_PC = ADDR_SIZE'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_SIZE-1:0]  imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_SIZE-1:0] imem_rsp_data,
    input  logic                  redirect,
    input  logic [ADDR_SIZE-1:0]  redirect_pc,
    input  logic                  stallF,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instrF,
    output logic [ADDR_SIZE-1:0]  pcF
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_ONE = CW'(1);
    localparam logic [PW-1:0]         PTR_ONE = PW'(1);
    localparam logic [INSTR_SIZE-1:0] NOP_I   = INSTR_SIZE'(NOP_INSTR);
    localparam logic [ADDR_SIZE-1:0]  STEP    = ADDR_SIZE'(PC_INC);

    logic [ADDR_SIZE-1:0]  fpc;
    logic [PW-1:0]         alloc;
    logic [PW-1:0]         fill;
    logic [PW-1:0]         head;
    logic [CW-1:0]         used;
    logic [CW-1:0]         drop;

    logic [CW:0]           occupancy;
    logic [PW-1:0]         ptr_gap;
    logic [CW-1:0]         pend;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         drop_redirect;
    logic                  fire;
    logic                  deq;
    logic                  rsp_live;
    logic                  fill_en;
    logic                  head_filled;
    logic [ADDR_SIZE-1:0]  head_pc;
    logic [INSTR_SIZE-1:0] head_instr;

    // Requests still owed by memory count against capacity, so in-flight never exceeds DEPTH.
    assign occupancy      = {1'b0, used} + {1'b0, drop};
    assign imem_req_valid = reset && !redirect && (occupancy < {1'b0, DEPTH_C});
    assign imem_req_addr  = fpc;
    assign fire           = imem_req_valid && imem_req_ready;

    // A response belongs to a live entry only once every pre-redirect word has been discarded.
    assign rsp_live = imem_rsp_valid && (drop == '0);

    // Live requests awaiting data = alloc - fill. Equal pointers with a full ring and an
    // unfilled head means all DEPTH entries are still waiting, not none.
    assign ptr_gap = alloc - fill;
    assign pend    = (ptr_gap == '0 && used == DEPTH_C && !head_filled) ? DEPTH_C : {1'b0, ptr_gap};
    assign outstanding = drop + pend;

    // A response arriving in the redirect cycle is treated as already answered.
    assign drop_redirect = (imem_rsp_valid && outstanding != '0) ? outstanding - CNT_ONE : outstanding;

`ifdef IFQ_BYPASS_EN
    logic bypass_hit;
    // The word in flight is the head's own instruction: present it before it is written.
    assign bypass_hit  = rsp_live && (used != '0) && (fill == head) && !head_filled;
    assign instr_valid = head_filled || bypass_hit;
    assign instrF      = head_filled ? head_instr : (bypass_hit ? imem_rsp_data : NOP_I);
    assign deq         = instr_valid && !stallF && !redirect;
    // Consumed straight from the bus, so the ring write is skipped.
    assign fill_en     = rsp_live && !redirect && !(bypass_hit && deq);
`else
    assign instr_valid = head_filled;
    assign instrF      = head_filled ? head_instr : NOP_I;
    assign deq         = instr_valid && !stallF && !redirect;
    assign fill_en     = rsp_live && !redirect;
`endif

    assign pcF = (used != '0) ? head_pc : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc   <= RESET_PC;
            alloc <= '0;
            fill  <= '0;
            head  <= '0;
            used  <= '0;
            drop  <= '0;
        end else if (redirect) begin
            fpc   <= redirect_pc;
            alloc <= '0;
            fill  <= '0;
            head  <= '0;
            used  <= '0;
            drop  <= drop_redirect;
        end else begin
            if (fire) begin
                fpc   <= fpc + STEP;
                alloc <= alloc + PTR_ONE;
            end
            if (imem_rsp_valid) begin
                if (drop != '0) begin
                    drop <= drop - CNT_ONE;
                end else begin
                    fill <= fill + PTR_ONE;
                end
            end
            if (deq) begin
                head <= head + PTR_ONE;
            end
            case ({fire, deq})
                2'b10:   used <= used + CNT_ONE;
                2'b01:   used <= used - CNT_ONE;
                default: used <= used;
            endcase
        end
    end

    ifq_ring #(
        .DEPTH      (DEPTH),
        .ADDR_SIZE  (ADDR_SIZE),
        .INSTR_SIZE (INSTR_SIZE)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .clear       (redirect),
        .alloc_en    (fire),
        .alloc_idx   (alloc),
        .alloc_pc    (fpc),
        .fill_en     (fill_en),
        .fill_idx    (fill),
        .fill_instr  (imem_rsp_data),
        .deq_en      (deq),
        .head_idx    (head),
        .head_pc     (head_pc),
        .head_instr  (head_instr),
        .head_filled (head_filled)
    );

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch front end sitting directly upstream of the pipelined datapath's IF/ID register. It owns the fetch PC, issues in-order requests to an instruction memory with arbitrary response latency, buffers returned words with their PCs in a small queue, and presents one instruction per cycle as `instrF`/`pcF`. Stall and redirect inputs replace the datapath's internal PC register and next-PC mux.

## Interface
- `DEPTH`, 4: queue entries and maximum in-flight requests; power of two, ≥2.
- `ADDR_SIZE`, 32: PC width.
- `INSTR_SIZE`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out ADDR_SIZE: fetch address.
- `imem_rsp_valid` in 1: one response word, strictly in request order.
- `imem_rsp_data` in INSTR_SIZE: returned instruction.
- `redirect` in 1: taken branch/jump resolved in EX.
- `redirect_pc` in ADDR_SIZE: target address.
- `stallF` in 1: load-use hold from the hazard unit; head is not consumed.
- `instr_valid` out 1: `instrF`/`pcF` hold a real instruction.
- `instrF` out INSTR_SIZE: head instruction; NOP 32'h0000_0013 when `instr_valid`=0.
- `pcF` out ADDR_SIZE: PC of head entry; 0 when empty.

## Operation
- State: fetch PC `fpc`; ring of DEPTH entries {pc, instr, filled}; pointers `alloc`, `fill`, `head` (log2 DEPTH bits, natural wrap); counters `used` (0..DEPTH), `drop` (0..DEPTH).
- Issue: `imem_req_valid` = !redirect && (used + drop < DEPTH); `imem_req_addr` = `fpc`. On fire (valid & ready): write `fpc` into entry `alloc`, clear filled, `alloc`++, `used`++, `fpc` += 4.
- Response: if `drop`>0, discard word, `drop`--. Else write data into entry `fill`, set filled, `fill`++.
- Output: `instr_valid` = head entry filled. Dequeue when `instr_valid` && !`stallF`: `head`++, `used`--.
- Simultaneous issue and dequeue: `used` unchanged. Full (`used`=DEPTH): no issue; memory ready ignored.
- Redirect (highest priority, overrides issue, fill, dequeue, stall): `fpc` ← `redirect_pc`; all pointers ← 0; `used` ← 0; `drop` ← (requests issued but not yet answered, counting any response in the same cycle as already answered); all filled bits cleared. Head of queue is not consumed.
- Misaligned `redirect_pc` (bits[1:0]≠0) is fetched as given; no trap is raised here.
- PC arithmetic is modulo 2^ADDR_SIZE; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `fpc`=RESET_PC, `imem_req_valid`=0 while reset asserted, `instr_valid`=0, `instrF`=32'h0000_0013, `pcF`=0, all counters/pointers 0.
- First request: first rising edge after reset deasserts, `imem_req_valid`=1, addr RESET_PC.
- Latency (default build): response at edge N → `instr_valid` from cycle N+1.
- Redirect at cycle R: `instr_valid`=0 in R+1; new request at `redirect_pc` issued in R+1.
- Reset asserted mid-operation: immediate clear; in-flight responses after deassert are not dropped (memory is reset together with this block).

## Configuration
- `IFQ_BYPASS_EN` defined: when the response targets the head entry and the head is unfilled, `instr_valid`/`instrF` are driven combinationally from `imem_rsp_data` in the same cycle; dequeue that cycle skips the write. Best-case fetch-to-issue latency drops by one cycle.
- Undefined: all outputs come from registered ring state only; no combinational path from `imem_rsp_*` to outputs.

## Structure
- Shared package `ifq_pkg`: `NOP_INSTR` (32'h0000_0013), default `RESET_PC`, PC increment constant 4.
- One sub-module `ifq_ring`: DEPTH-entry storage with separate pc-write (alloc) and instr-write (fill) ports and head read port; counters and redirect logic stay in `ifetch_queue`.

## Test plan
- Reset release, memory ready always, 1-cycle latency → requests 0x0,0x4,0x8…; `instr_valid` from third cycle; `pcF` increments by 4 each cycle.
- `imem_req_ready`=0 for 10 cycles, then 1 → no `fpc` advance while stalled; no duplicate or skipped PCs afterwards.
- `stallF`=1 with 4-cycle latency memory → exactly 4 requests outstanding/queued, `imem_req_valid`=0, `instrF`/`pcF` held constant.
- Three requests in flight, `redirect`=1 to 0x100 → three later responses discarded; first valid `pcF`=0x100 with its matching instruction.
- Redirect in same cycle as a response and a dequeue → response counted as answered (not in `drop`), nothing dequeued, next valid `pcF`=`redirect_pc`.
- Redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
